instruction_fetch_unit: RTL and testbench

Sequencer that drives the synchronous instruction ROM's read address and delivers fetched words to decode. It sits between the instruction memory and the decode stage and owns the program counter. It sustains one word per cycle, honours backpressure through a valid/ready handshake, accepts branch/jump redirects, and stops cleanly after the last memory location.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/fetch_skid_buffer.sv | 45 ++++
 rtl/instruction_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // Address width for a ROM of mem_length words (at least one bit).
  function automatic int fetch_aw(input int mem_length);
    return (mem_length > 1) ? $clog2(mem_length) : 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: control, ROM and decode-side signals of the fetch unit.
// master = fetch unit, slave = surrounding system (ROM, decode, sequencer control).
interface instruction_fetch_unit_if #(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32
);
  localparam int AW = fetch_pkg::fetch_aw(MEM_LENGTH);

  logic                   start;
  logic [AW-1:0]          start_addr;
  logic                   redirect_valid;
  logic [AW-1:0]          redirect_addr;
  logic [AW-1:0]          imem_address;
  logic [DATA_LENGTH-1:0] imem_data;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [DATA_LENGTH-1:0] instr_data;
  logic [AW-1:0]          instr_pc;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, start_addr, redirect_valid, redirect_addr, imem_data, instr_ready,
    output imem_address, instr_valid, instr_data, instr_pc, busy, done
  );

  modport slave (
    output start, start_addr, redirect_valid, redirect_addr, imem_data, instr_ready,
    input  imem_address, instr_valid, instr_data, instr_pc, busy, done
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO with registered outputs holding {pc, data}.
// flush empties it in one cycle; the fetch unit never pushes into a full buffer.
module fetch_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] entry_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = entry_q[rd_ptr_q];
  assign count     = count_q;

  // Storage, pointers and occupancy; flush discards everything held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues one ROM read per cycle and delivers
// words to decode over valid/ready, with redirects and a clean stop at the last word.
// Build option IFETCH_OUTREG_EN: decode-side outputs come from a 2-entry skid buffer
// (2-cycle issue-to-valid latency); otherwise outputs follow the ROM with 1-cycle latency.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32
) (
  input  logic clk,
  input  logic rst,
  instruction_fetch_unit_if.master bus
);
  localparam int AW = fetch_aw(MEM_LENGTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_LENGTH - 1);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          active, redirect, issue, seq_ok, drained;
  logic [AW-1:0] issue_addr, hold_addr;

  assign active           = (state_q == RUN) || (state_q == DRAIN);
  assign redirect         = active && bus.redirect_valid;
  assign bus.busy         = active;
  assign bus.done         = (state_q == DONE);
  assign bus.imem_address = issue_addr;

  // Next state, next PC and issue decision; redirect outranks stall and sequential issue.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue      = 1'b0;
    issue_addr = hold_addr;
    if (redirect) begin
      issue      = 1'b1;
      issue_addr = bus.redirect_addr;
      // A redirect onto the last word goes straight to DRAIN; the PC never wraps.
      if (bus.redirect_addr == LAST_ADDR) begin
        state_d = DRAIN;
        pc_d    = bus.redirect_addr;
      end else begin
        state_d = RUN;
        pc_d    = bus.redirect_addr + 1'b1;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = RUN;
            pc_d    = bus.start_addr;
          end
        end
        RUN: begin
          if (seq_ok) begin
            issue      = 1'b1;
            issue_addr = pc_q;
            if (pc_q == LAST_ADDR) state_d = DRAIN;
            else                   pc_d    = pc_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drained) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IFETCH_OUTREG_EN
  logic                      inflight_q;
  logic [AW-1:0]             inflight_pc_q;
  logic [1:0]                occupancy;
  logic                      push, pop, skid_valid;
  logic [AW+DATA_LENGTH-1:0] skid_out;

  assign pop       = skid_valid && bus.instr_ready;
  // The read in flight during a redirect is dropped instead of buffered.
  assign push      = inflight_q && !redirect;
  // Issue only if the word can land without overflowing the buffer.
  assign seq_ok    = ({1'b0, occupancy} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign drained   = !inflight_q && ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop));
  assign hold_addr = pc_q;

  assign bus.instr_valid = skid_valid;
  assign bus.instr_pc    = skid_out[AW+DATA_LENGTH-1:DATA_LENGTH];
  assign bus.instr_data  = skid_out[DATA_LENGTH-1:0];

  // Remember the read issued this cycle; its data appears on imem_data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) inflight_pc_q <= issue_addr;
    end
  end

  fetch_skid_buffer #(
    .WIDTH(AW + DATA_LENGTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({inflight_pc_q, bus.imem_data}),
    .pop       (pop),
    .out_valid (skid_valid),
    .out_data  (skid_out),
    .count     (occupancy)
  );
`else
  logic          valid_q, valid_d, stall;
  logic [AW-1:0] ipc_q, ipc_d;

  assign stall   = valid_q && !bus.instr_ready;
  assign seq_ok  = !stall;
  assign drained = !stall;
  // While stalled the ROM re-reads the presented word so its output holds steady.
  assign hold_addr = stall ? ipc_q : pc_q;

  assign bus.instr_valid = valid_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_data  = valid_q ? bus.imem_data : '0;

  // Presented word: a fresh issue replaces it, a stall keeps it, otherwise it retires.
  always_comb begin
    valid_d = 1'b0;
    ipc_d   = ipc_q;
    if (issue) begin
      valid_d = 1'b1;
      ipc_d   = issue_addr;
    end else if (stall) begin
      valid_d = valid_q;
    end
  end

  // Output-side valid and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ipc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed, table-driven bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
  localparam int DL = 32;
  localparam int ML = 32;
  localparam int AW = 5;
`ifdef IFETCH_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int start_addr;
    int stall_pc;
    int stall_len;
    int redir_pc;
    int redir_addr;
    int exp_count;
    int exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [DL-1:0] rom [ML];

  instruction_fetch_unit_if #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) bus ();

  instruction_fetch_unit #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.imem_data <= rom[bus.imem_address];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus.instr_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_imem_address"}, int'(bus.imem_address), 0);
    chk({tag, "_instr_pc"}, int'(bus.instr_pc), 0);
    chk({tag, "_instr_data"}, int'(bus.instr_data), 0);
  endtask

  task automatic run_scenario(input vec_t v);
    int cyc, n_acc, sum_acc, first_cyc, last_cyc, exp_pc, last_pc, stall_left, redir_cyc, done_cyc;
    bit stall_started, redir_used, wait_target, seen_first, finished;
    cyc = 1; n_acc = 0; sum_acc = 0; first_cyc = -1; last_cyc = -1; exp_pc = v.start_addr;
    last_pc = -1; stall_left = 0; redir_cyc = -1; done_cyc = -1;
    stall_started = 0; redir_used = 0; wait_target = 0; seen_first = 0; finished = 0;
    bus.start = 1'b1;
    bus.start_addr = AW'(v.start_addr);
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!finished && cyc < 400) begin
      if (cyc == 1) begin
        chk("busy_after_start", int'(bus.busy), 1);
        chk("done_after_start", int'(bus.done), 0);
      end
      if (!seen_first && bus.instr_valid) begin
        seen_first = 1;
        chk("start_latency", cyc, 1 + LAT);
      end
      if (wait_target && bus.instr_valid) begin
        wait_target = 0;
        chk("redirect_target_pc", int'(bus.instr_pc), v.redir_addr);
        chk("redirect_latency", cyc - redir_cyc, LAT);
      end
      if (bus.done) begin
        finished = 1;
        done_cyc = cyc;
      end else begin
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.start = (cyc == 8);
        if (cyc == 8) bus.start_addr = '0;
        if (!stall_started && bus.instr_valid && int'(bus.instr_pc) == v.stall_pc) begin
          stall_started = 1;
          stall_left = v.stall_len;
        end
        if (stall_left > 0) begin
          bus.instr_ready = 1'b0;
          stall_left--;
        end else if (!redir_used && v.redir_pc >= 0 && bus.instr_valid &&
                     int'(bus.instr_pc) == v.redir_pc) begin
          bus.redirect_valid = 1'b1;
          bus.redirect_addr = AW'(v.redir_addr);
          redir_used = 1;
          redir_cyc = cyc;
          wait_target = 1;
        end
        #1;
        if (!bus.instr_ready) begin
          chk("stall_valid", int'(bus.instr_valid), 1);
          chk("stall_pc", int'(bus.instr_pc), v.stall_pc);
          chk("stall_data", int'(bus.instr_data), v.stall_pc);
`ifndef IFETCH_OUTREG_EN
          chk("stall_reread_addr", int'(bus.imem_address), v.stall_pc);
`endif
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
          $display("xfer cyc=%0d pc=%0d data=%0d", cyc, bus.instr_pc, bus.instr_data);
          chk("accept_order", int'(bus.instr_pc), exp_pc);
          chk("accept_data", int'(bus.instr_data), int'(bus.instr_pc));
          n_acc++;
          sum_acc += int'(bus.instr_pc);
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          last_pc = int'(bus.instr_pc);
          exp_pc = last_pc + 1;
        end
        if (bus.redirect_valid) exp_pc = v.redir_addr;
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("scenario_reaches_done", int'(finished), 1);
    chk("accepted_count", n_acc, v.exp_count);
    chk("accepted_sum", sum_acc, v.exp_sum);
    chk("last_pc_before_done", last_pc, ML - 1);
    chk("done_after_last_accept", done_cyc - last_cyc, 1);
    chk("throughput_span", last_cyc - first_cyc,
        v.exp_count - 1 + v.stall_len + (redir_used ? LAT : 0));
    chk("busy_in_done", int'(bus.busy), 0);
    // A redirect in DONE must not restart fetching.
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = AW'(5);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_ignores_redirect_done", int'(bus.done), 1);
    chk("done_ignores_redirect_valid", int'(bus.instr_valid), 0);
    $display("scenario start=%0d accepted=%0d sum=%0d", v.start_addr, n_acc, sum_acc);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t rst_vec;
    bit found;
    vecs[0] = '{start_addr: 0, stall_pc: -1, stall_len: 0, redir_pc: -1, redir_addr: 0,
                exp_count: 32, exp_sum: 496};
    vecs[1] = '{start_addr: 4, stall_pc: 6, stall_len: 3, redir_pc: -1, redir_addr: 0,
                exp_count: 28, exp_sum: 490};
    vecs[2] = '{start_addr: 0, stall_pc: -1, stall_len: 0, redir_pc: 3, redir_addr: 20,
                exp_count: 15, exp_sum: 309};
    vecs[3] = '{start_addr: 0, stall_pc: -1, stall_len: 0, redir_pc: 31, redir_addr: 10,
                exp_count: 53, exp_sum: 916};
    rst_vec = '{start_addr: 12, stall_pc: -1, stall_len: 0, redir_pc: -1, redir_addr: 0,
                exp_count: 20, exp_sum: 430};
    for (int i = 0; i < ML; i++) rom[i] = DL'(i);

    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    bus.instr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_scenario(vecs[i]);

    // Reset in the middle of a stall on pc 12.
    bus.start = 1'b1;
    bus.start_addr = '0;
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (bus.instr_valid && int'(bus.instr_pc) == 12) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("reach_pc12", int'(found), 1);
    bus.instr_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("midrun_reset");
    bus.instr_ready = 1'b1;
    run_scenario(rst_vec);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
